// File: rtl/mpu_det_sequencer.sv
// Sequenced determinant controller: Laplace expansion along row 0, one minor per cycle
// through a single shared 3x3 determinant evaluator, all arithmetic mod 256.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands latched on start
// EVAL  | one expansion step per cycle, accumulating into acc_q
// DONE  | done pulse with result/error valid; a new start is taken here
module mpu_det_sequencer (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic signed [7:0]  size,
    input  logic [199:0]       matrix,
    output logic               busy,
    output logic               done,
    output logic signed [7:0]  result,
    output logic               error
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [199:0]        mat_q, mat_d;
    logic signed [7:0]   size_q, size_d;
    logic [7:0]          acc_q, acc_d;
    logic [4:0]          step_q, step_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          result_q, result_d;
    logic                error_q, error_d;

    logic [7:0] a [5][5];
    logic [2:0] i_idx, j_idx, cj, lo, hi, r0, c0, c1, c2;
    logic [7:0] coef, minor, term, acc_next;
    logic       neg, last_step, size_ok;

    function automatic logic [7:0] det3(
        input logic [7:0] m00, input logic [7:0] m01, input logic [7:0] m02,
        input logic [7:0] m10, input logic [7:0] m11, input logic [7:0] m12,
        input logic [7:0] m20, input logic [7:0] m21, input logic [7:0] m22
    );
        return m00 * (m11 * m22 - m12 * m21)
             - m01 * (m10 * m22 - m12 * m20)
             + m02 * (m10 * m21 - m11 * m20);
    endfunction

    // k-th element of an ascending index list with x removed
    function automatic logic [2:0] skip1(input logic [2:0] k, input logic [2:0] x);
        return (k >= x) ? k + 3'd1 : k;
    endfunction

    always_comb begin
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                a[r][c] = mat_q[8*(c+5*r) +: 8];
            end
        end
    end

    always_comb begin
        i_idx = step_q[4:2];
        j_idx = {1'b0, step_q[1:0]};
        cj    = skip1(j_idx, i_idx);
        lo    = (i_idx < cj) ? i_idx : cj;
        hi    = (i_idx < cj) ? cj : i_idx;
        r0    = 3'd0;
        c0    = 3'd0;
        c1    = 3'd1;
        c2    = 3'd2;
        coef  = 8'd1;
        neg   = 1'b0;
        case (size_q)
            8'sd4: begin
                r0   = 3'd1;
                c0   = skip1(3'd0, j_idx);
                c1   = skip1(3'd1, j_idx);
                c2   = skip1(3'd2, j_idx);
                coef = a[0][j_idx];
                neg  = j_idx[0];
            end
            8'sd5: begin
                r0   = 3'd2;
                c0   = skip1(skip1(3'd0, lo), hi);
                c1   = skip1(skip1(3'd1, lo), hi);
                c2   = skip1(skip1(3'd2, lo), hi);
                coef = a[0][i_idx] * a[1][cj];
                neg  = i_idx[0] ^ j_idx[0];
            end
            default: ;
        endcase

        minor = det3(a[r0][c0],        a[r0][c1],        a[r0][c2],
                     a[r0+3'd1][c0],   a[r0+3'd1][c1],   a[r0+3'd1][c2],
                     a[r0+3'd2][c0],   a[r0+3'd2][c1],   a[r0+3'd2][c2]);

        case (size_q)
            8'sd1:   term = a[0][0];
            8'sd2:   term = a[0][0] * a[1][1] - a[0][1] * a[1][0];
            8'sd3:   term = minor;
            8'sd4,
            8'sd5:   term = coef * minor;
            default: term = 8'd0;
        endcase

        acc_next  = neg ? acc_q - term : acc_q + term;
        size_ok   = (size_q >= 8'sd1) && (size_q <= 8'sd5);
        last_step = (size_q == 8'sd5) ? (step_q == 5'd19)
                  : (size_q == 8'sd4) ? (step_q == 5'd3)
                  : 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        mat_d    = mat_q;
        size_d   = size_q;
        acc_d    = acc_q;
        step_d   = step_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        error_d  = error_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE also accepts start so back-to-back jobs issue every N+1 cycles
                if (start) begin
                    state_d = S_EVAL;
                    mat_d   = matrix;
                    size_d  = size;
                    acc_d   = 8'd0;
                    step_d  = 5'd0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EVAL: begin
                if (last_step) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    step_d   = 5'd0;
                    acc_d    = acc_next;
                    result_d = size_ok ? acc_next : 8'd0;
                    error_d  = ~size_ok;
                end else begin
                    acc_d  = acc_next;
                    step_d = step_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            mat_q    <= '0;
            size_q   <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mat_q    <= mat_d;
            size_q   <= size_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign error  = error_q;

endmodule

// File: tb/tb_mpu_det_sequencer.sv
// Directed bench for mpu_det_sequencer: latency, busy window, results mod 256,
// invalid sizes, held start with operand change, and mid-job reset.
module tb_mpu_det_sequencer;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start;
    logic signed [7:0] size;
    logic [199:0]      matrix;
    logic              busy;
    logic              done;
    logic signed [7:0] result;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [199:0] m_full, m_id5, m_d3, m_d4, m_p4, m2a, m2b, m3, m1;

    mpu_det_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .size    (size),
        .matrix  (matrix),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .error   (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%02h), expected %0d (0x%02h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic logic [199:0] set_row(input logic [199:0] m, input int r,
                                             input int v0, input int v1, input int v2,
                                             input int v3, input int v4);
        logic [199:0] t;
        t = m;
        t[8*(5*r+0) +: 8] = 8'(v0);
        t[8*(5*r+1) +: 8] = 8'(v1);
        t[8*(5*r+2) +: 8] = 8'(v2);
        t[8*(5*r+3) +: 8] = 8'(v3);
        t[8*(5*r+4) +: 8] = 8'(v4);
        return t;
    endfunction

    task automatic start_job(input logic [7:0] s, input logic [199:0] m);
        @(negedge clock);
        size   = s;
        matrix = m;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start  = 1'b0;
    endtask

    // Called 1ns after the accepting edge; returns edges until done and busy samples seen.
    task automatic wait_done(input int limit, output int edges, output int busy_cnt,
                             output int overlap);
        edges    = 0;
        busy_cnt = busy ? 1 : 0;
        overlap  = 0;
        while (edges < limit) begin
            @(posedge clock);
            #1;
            edges++;
            if (busy && done) overlap++;
            if (done) break;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_job(input string tag, input logic [7:0] s, input logic [199:0] m,
                           input int n_exp, input logic [7:0] res_exp, input logic err_exp);
        int e, b, ov;
        start_job(s, m);
        check({tag, "_busy_start"}, 8'(busy), 8'd1);
        wait_done(40, e, b, ov);
        check({tag, "_latency"}, 8'(e), 8'(n_exp));
        check({tag, "_busy_cycles"}, 8'(b), 8'(n_exp));
        check({tag, "_busy_done_overlap"}, 8'(ov), 8'd0);
        check({tag, "_result"}, result, res_exp);
        check({tag, "_error"}, 8'(error), 8'(err_exp));
    endtask

    initial begin
        int e, b, ov, dn, bz;

        m_full = '0;
        m_full = set_row(m_full, 0, 1, 2, 0, 0, 1);
        m_full = set_row(m_full, 1, 0, 1, 3, 0, 0);
        m_full = set_row(m_full, 2, 2, 0, 1, 1, 0);
        m_full = set_row(m_full, 3, 0, 0, 2, 1, 3);
        m_full = set_row(m_full, 4, 1, 0, 0, 2, 1);
        m_id5 = '0;
        m_d3  = '0;
        for (int k = 0; k < 5; k++) begin
            m_id5[8*(6*k) +: 8] = 8'd1;
            m_d3[8*(6*k) +: 8]  = 8'd3;
        end
        m_d4 = '0;
        m_d4 = set_row(m_d4, 0, 2, 0, 0, 0, 99);
        m_d4 = set_row(m_d4, 1, 0, 3, 0, 0, 99);
        m_d4 = set_row(m_d4, 2, 0, 0, 4, 0, 99);
        m_d4 = set_row(m_d4, 3, 0, 0, 0, 5, 99);
        m_d4 = set_row(m_d4, 4, 77, 77, 77, 77, 77);
        m_p4 = '0;
        m_p4 = set_row(m_p4, 0, 0, 1, 0, 0, 0);
        m_p4 = set_row(m_p4, 1, 1, 0, 0, 0, 0);
        m_p4 = set_row(m_p4, 2, 0, 0, 1, 0, 0);
        m_p4 = set_row(m_p4, 3, 0, 0, 0, 1, 0);
        m2a = '0;
        m2a = set_row(m2a, 0, 3, 4, 11, 11, 11);
        m2a = set_row(m2a, 1, 2, 5, 11, 11, 11);
        m2b = '0;
        m2b = set_row(m2b, 0, 5, -3, 0, 0, 0);
        m2b = set_row(m2b, 1, 4, 2, 0, 0, 0);
        m3 = '0;
        m3 = set_row(m3, 0, 2, 1, 0, 0, 0);
        m3 = set_row(m3, 1, 1, 3, 1, 0, 0);
        m3 = set_row(m3, 2, 0, 1, 4, 0, 0);
        m1 = '0;
        m1 = set_row(m1, 0, -7, 9, 9, 9, 9);

        reset_n = 1'b0;
        start   = 1'b0;
        size    = '0;
        matrix  = '0;
        #12;
        check("reset_busy", 8'(busy), 8'd0);
        check("reset_done", 8'(done), 8'd0);
        check("reset_result", result, 8'd0);
        check("reset_error", 8'(error), 8'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_job("s2", 8'd2, m2a, 1, 8'd7, 1'b0);
        run_job("s3_b2b", 8'd3, m3, 1, 8'd18, 1'b0);
        @(posedge clock);
        #1;
        check("done_pulse_width", 8'(done), 8'd0);
        check("result_held", result, 8'd18);

        run_job("s4_diag", 8'd4, m_d4, 4, 8'd120, 1'b0);
        run_job("s4_perm", 8'd4, m_p4, 4, 8'(-1), 1'b0);

        run_job("s5_ident", 8'd5, m_id5, 20, 8'd1, 1'b0);
        run_job("s5_diag3", 8'd5, m_d3, 20, 8'(-13), 1'b0);
        run_job("s5_full", 8'd5, m_full, 20, 8'(-56), 1'b0);

        run_job("size0", 8'd0, m_full, 1, 8'd0, 1'b1);
        @(posedge clock);
        #1;
        check("error_held_idle", 8'(error), 8'd1);
        run_job("size6", 8'd6, m_full, 1, 8'd0, 1'b1);
        run_job("size_m1", 8'hFF, m_full, 1, 8'd0, 1'b1);
        run_job("s1_neg7", 8'd1, m1, 1, 8'(-7), 1'b0);

        // start held high, operands changed mid-job
        @(negedge clock);
        size   = 8'sd5;
        matrix = m_full;
        start  = 1'b1;
        @(posedge clock);
        #1;
        e  = 0;
        dn = 0;
        while (e < 40) begin
            @(posedge clock);
            #1;
            e++;
            if (e == 5) matrix = m_id5;
            if (done) begin
                dn++;
                break;
            end
        end
        check("held_latency", 8'(e), 8'd20);
        check("held_done_count", 8'(dn), 8'd1);
        check("held_result", result, 8'(-56));
        @(posedge clock);
        #1;
        check("held_next_accept", 8'(busy), 8'd1);
        check("held_next_no_done", 8'(done), 8'd0);
        start = 1'b0;
        wait_done(40, e, b, ov);
        check("held_next_latency", 8'(e), 8'd20);
        check("held_next_result", result, 8'd1);

        // reset in the middle of a size-5 job
        start_job(8'd5, m_full);
        repeat (10) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 8'(busy), 8'd0);
        check("midrst_done", 8'(done), 8'd0);
        check("midrst_result", result, 8'd0);
        check("midrst_error", 8'(error), 8'd0);
        @(negedge clock);
        reset_n = 1'b1;
        dn = 0;
        bz = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (done) dn++;
            if (busy) bz++;
        end
        check("midrst_no_done", 8'(dn), 8'd0);
        check("midrst_no_busy", 8'(bz), 8'd0);
        run_job("after_rst_s2", 8'd2, m2b, 1, 8'd22, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
